// File: rtl/kernel_run_ctrl.sv
// rtl/kernel_run_ctrl.sv - single-invocation run sequencer and array-port arbiter for a synthesized kernel
//
// Purpose:
//   Launches one run of a kernel, waits for its completion (rising edge of
//   k_w_enable) or for a cycle-budget timeout, and captures the result and
//   the run length. It also owns the mux in front of the kernel's external
//   single-port array RAM. The host owns the port while idle and the kernel
//   owns it while a run is in flight.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   host_start/arg     run request (accepted only in IDLE) and kernel argument
//   host_busy          high while LAUNCH or RUN
//   host_done          one-cycle pulse on completion or timeout
//   host_timeout       sticky, last run aborted by timeout
//   host_result        kernel result captured on completion
//   host_cycles        RUN cycle count of the last run
//   host_mem_*         host side of the array port (grant, we, addr, wdata, rdata)
//   k_r_enable/k_init  kernel start pulse and argument
//   k_w_enable/result  kernel completion level and result
//   k_arr_*            kernel side of the array port
//   mem_*              physical RAM port (read data registered inside the RAM)

module kernel_run_ctrl #(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              host_start,
    input  logic [DATA_W-1:0] host_arg,
    output logic              host_busy,
    output logic              host_done,
    output logic              host_timeout,
    output logic [DATA_W-1:0] host_result,
    output logic [31:0]       host_cycles,

    output logic              host_mem_grant,
    input  logic              host_mem_we,
    input  logic [ADDR_W-1:0] host_mem_addr,
    input  logic [DATA_W-1:0] host_mem_wdata,
    output logic [DATA_W-1:0] host_mem_rdata,

    output logic              k_r_enable,
    output logic [DATA_W-1:0] k_init,
    input  logic              k_w_enable,
    input  logic [DATA_W-1:0] k_result,
    input  logic              k_arr_we,
    input  logic [ADDR_W-1:0] k_arr_addr,
    input  logic [DATA_W-1:0] k_arr_wdata,
    output logic [DATA_W-1:0] k_arr_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_VAL  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_VAL - 32'd1;

    state_t              state_q,        state_d;
    logic                k_r_enable_q,   k_r_enable_d;
    logic [DATA_W-1:0]   k_init_q,       k_init_d;
    logic                busy_q,         busy_d;
    logic                done_q,         done_d;
    logic                timeout_q,      timeout_d;
    logic [DATA_W-1:0]   result_q,       result_d;
    logic [31:0]         cycles_q,       cycles_d;
    logic                grant_q,        grant_d;
    logic                wen_hist_q,     wen_hist_d;
    logic [31:0]         cnt_q,          cnt_d;

    logic                wen_rise;
    logic                timeout_hit;
    logic [31:0]         cnt_inc;

    // Completion is an edge, not a level: a kernel that leaves w_enable high
    // from its previous run must drop it and raise it again.
    assign wen_rise    = k_w_enable & ~wen_hist_q;
    assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);
    assign cnt_inc     = (cnt_q == 32'hffff_ffff) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d      = state_q;
        k_init_d     = k_init_q;
        done_d       = 1'b0;
        timeout_d    = timeout_q;
        result_d     = result_q;
        cycles_d     = cycles_q;
        cnt_d        = cnt_q;
        wen_hist_d   = k_w_enable;

        case (state_q)
            ST_IDLE: begin
                // A start arriving alongside the done pulse is dropped so the
                // host always sees the pulse before a new run can begin.
                if (host_start && !done_q) begin
                    state_d   = ST_LAUNCH;
                    k_init_d  = host_arg;
                    timeout_d = 1'b0;
                    cnt_d     = 32'd0;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (wen_rise) begin
                    state_d  = ST_IDLE;
                    result_d = k_result;
                    cycles_d = cnt_inc;
                    done_d   = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    cycles_d  = TIMEOUT_VAL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // exactly with the state they describe.
        k_r_enable_d = (state_d == ST_LAUNCH);
        busy_d       = (state_d != ST_IDLE);
        grant_d      = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            k_r_enable_q <= 1'b0;
            k_init_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            result_q     <= '0;
            cycles_q     <= 32'd0;
            grant_q      <= 1'b1;
            wen_hist_q   <= 1'b0;
            cnt_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            k_r_enable_q <= k_r_enable_d;
            k_init_q     <= k_init_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            result_q     <= result_d;
            cycles_q     <= cycles_d;
            grant_q      <= grant_d;
            wen_hist_q   <= wen_hist_d;
            cnt_q        <= cnt_d;
        end
    end

    assign host_busy      = busy_q;
    assign host_done      = done_q;
    assign host_timeout   = timeout_q;
    assign host_result    = result_q;
    assign host_cycles    = cycles_q;
    assign host_mem_grant = grant_q;
    assign k_r_enable     = k_r_enable_q;
    assign k_init         = k_init_q;

    // The non-owner's write strobe is simply not forwarded, so its write is lost.
    assign mem_we    = grant_q ? host_mem_we    : k_arr_we;
    assign mem_addr  = grant_q ? host_mem_addr  : k_arr_addr;
    assign mem_wdata = grant_q ? host_mem_wdata : k_arr_wdata;

    assign host_mem_rdata = mem_rdata;
    assign k_arr_rdata    = mem_rdata;

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// tb/tb_kernel_run_ctrl.sv - self-checking bench for kernel_run_ctrl
module tb_kernel_run_ctrl;

    localparam int DW = 64;
    localparam int AW = 1;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_start;
    logic [DW-1:0] host_arg;
    logic          host_busy, host_done, host_timeout;
    logic [DW-1:0] host_result;
    logic [31:0]   host_cycles;
    logic          host_mem_grant, host_mem_we;
    logic [AW-1:0] host_mem_addr;
    logic [DW-1:0] host_mem_wdata, host_mem_rdata;
    logic          k_r_enable;
    logic [DW-1:0] k_init;
    logic          k_w_enable;
    logic [DW-1:0] k_result;
    logic          k_arr_we;
    logic [AW-1:0] k_arr_addr;
    logic [DW-1:0] k_arr_wdata, k_arr_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] ram [2];

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] model_res;

    typedef struct {
        logic [DW-1:0] arg;
        int            lat;
        logic [DW-1:0] res;
        bit            prev_high;
        bit            mem_act;
        int            exp_cycles;
        bit            exp_to;
        logic [DW-1:0] exp_res;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    kernel_run_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_start(host_start), .host_arg(host_arg),
        .host_busy(host_busy), .host_done(host_done), .host_timeout(host_timeout),
        .host_result(host_result), .host_cycles(host_cycles),
        .host_mem_grant(host_mem_grant), .host_mem_we(host_mem_we),
        .host_mem_addr(host_mem_addr), .host_mem_wdata(host_mem_wdata),
        .host_mem_rdata(host_mem_rdata),
        .k_r_enable(k_r_enable), .k_init(k_init), .k_w_enable(k_w_enable),
        .k_result(k_result), .k_arr_we(k_arr_we), .k_arr_addr(k_arr_addr),
        .k_arr_wdata(k_arr_wdata), .k_arr_rdata(k_arr_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},    host_busy,      0);
        chk({tag, "_done"},    host_done,      0);
        chk({tag, "_timeout"}, host_timeout,   0);
        chk({tag, "_result"},  host_result,    0);
        chk({tag, "_cycles"},  host_cycles,    0);
        chk({tag, "_ren"},     k_r_enable,     0);
        chk({tag, "_kinit"},   k_init,         0);
        chk({tag, "_grant"},   host_mem_grant, 1);
    endtask

    // Start a run at the current negedge (IDLE), play the kernel, check the outcome.
    task automatic run(input vec_t v, input bit rnd, input bit start_in_done);
        int  done_k, ren_cnt, busy_cnt, exp_done;
        bit  exp_grant;
        exp_done   = v.exp_cycles + 2;
        host_arg   = v.arg;
        k_result   = v.res;
        k_w_enable = v.prev_high;
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        chk("launch_k_init",  k_init,         v.arg);
        chk("launch_grant",   host_mem_grant, 0);
        chk("launch_to_clr",  host_timeout,   0);
        k_w_enable = 1'b0;
        done_k = 0; ren_cnt = 0; busy_cnt = 0;
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (k_r_enable) ren_cnt++;
            if (host_busy)  busy_cnt++;
            if (host_done)  done_k = k;
            if (done_k == 0) begin
                if (k == v.lat + 1) k_w_enable = 1'b1;
                if (rnd) begin
                    host_start     = 1'($urandom_range(0, 1));
                    host_mem_we    = 1'($urandom_range(0, 1));
                    host_mem_addr  = 1'($urandom_range(0, 1));
                    host_mem_wdata = {$urandom, $urandom};
                    k_arr_we       = 1'($urandom_range(0, 1));
                    k_arr_addr     = 1'($urandom_range(0, 1));
                    k_arr_wdata    = {$urandom, $urandom};
                end else if (v.mem_act) begin
                    host_mem_we = 1'b1; host_mem_addr = 1'b0; host_mem_wdata = 64'd99;
                    k_arr_we    = 1'b1; k_arr_addr    = 1'b1; k_arr_wdata    = 64'd3;
                end
            end else begin
                host_mem_we = 1'b0;
                k_arr_we    = 1'b0;
                host_start  = start_in_done;
                if (start_in_done) host_arg = 64'hdead;
            end
            if (rnd) begin
                #1;
                exp_grant = (k >= exp_done);
                chk("mux_grant", host_mem_grant, exp_grant);
                chk("mux_we",    mem_we,    exp_grant ? host_mem_we    : k_arr_we);
                chk("mux_addr",  mem_addr,  exp_grant ? host_mem_addr  : k_arr_addr);
                chk("mux_wdata", mem_wdata, exp_grant ? host_mem_wdata : k_arr_wdata);
                chk("rdata_fan", k_arr_rdata, mem_rdata);
            end
        end
        chk("done_cycle",    done_k,       exp_done);
        chk("ren_once",      ren_cnt,      1);
        chk("busy_cycles",   busy_cnt,     v.exp_cycles + 1);
        chk("host_cycles",   host_cycles,  v.exp_cycles);
        chk("host_timeout",  host_timeout, v.exp_to);
        chk("host_result",   host_result,  v.exp_res);
        @(negedge clk);
        chk("done_width",    host_done,      0);
        chk("idle_busy",     host_busy,      0);
        chk("idle_grant",    host_mem_grant, 1);
        model_res = v.exp_res;
    endtask

    initial begin
        vec_t rv;
        int   lat;

        //        arg                     lat res        ph mem cyc to res
        tbl[0] = '{64'hffff_ffff_ffff_fff9, 12, 64'd21,    0, 1,  12, 0, 64'd21};
        tbl[1] = '{64'd3,                    4, 64'h55,    1, 0,   4, 0, 64'h55};
        tbl[2] = '{64'h10,                  16, 64'h77,    0, 0,  16, 0, 64'h77};
        tbl[3] = '{64'h11,                  99, 64'hbad,   0, 0,  16, 1, 64'h77};
        tbl[4] = '{64'h12,                   1, 64'habc,   1, 0,   1, 0, 64'habc};
        tbl[5] = '{64'h13,                  17, 64'hbad2,  0, 0,  16, 1, 64'habc};

        rst_n = 1'b0; host_start = 1'b0; host_arg = '0;
        host_mem_we = 1'b0; host_mem_addr = '0; host_mem_wdata = '0;
        k_w_enable = 1'b0; k_result = '0;
        k_arr_we = 1'b0; k_arr_addr = '0; k_arr_wdata = '0;
        model_res = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Host preload and readback.
        host_mem_we = 1'b1; host_mem_addr = 1'b0; host_mem_wdata = 64'd5;
        @(negedge clk);
        host_mem_addr = 1'b1; host_mem_wdata = 64'd16;
        @(negedge clk);
        host_mem_we = 1'b0; host_mem_addr = 1'b0;
        @(negedge clk);
        chk("preload_rd0", host_mem_rdata, 64'd5);
        host_mem_addr = 1'b1;
        @(negedge clk);
        chk("preload_rd1", host_mem_rdata, 64'd16);
        chk("preload_krd", k_arr_rdata,    64'd16);

        // Table-driven runs.
        for (int i = 0; i < 6; i++) begin
            run(tbl[i], 1'b0, 1'b0);
            if (i == 0) begin
                host_mem_addr = 1'b0;
                @(negedge clk);
                chk("own_rd0", host_mem_rdata, 64'd5);
                host_mem_addr = 1'b1;
                @(negedge clk);
                chk("own_rd1", host_mem_rdata, 64'd3);
            end
        end

        // Start request coinciding with the done pulse is dropped, then accepted.
        rv = '{64'h21, 2, 64'h4242, 0, 0, 2, 0, 64'h4242};
        run(rv, 1'b0, 1'b1);
        k_result = 64'h5151;
        @(negedge clk);
        chk("sid_busy",  host_busy,  1);
        chk("sid_ren",   k_r_enable, 1);
        chk("sid_kinit", k_init,     64'hdead);
        host_start = 1'b0; k_w_enable = 1'b0;
        @(negedge clk);
        k_w_enable = 1'b1;
        for (int i = 0; i < 24 && !host_done; i++) @(negedge clk);
        chk("sid_done",   host_done,   1);
        chk("sid_cycles", host_cycles, 1);
        chk("sid_result", host_result, 64'h5151);
        model_res = 64'h5151;
        @(negedge clk);

        // Randomized runs against the run-level reference model.
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            lat           = $urandom_range(1, TO + 4);
            rv.arg        = {$urandom, $urandom};
            rv.lat        = lat;
            rv.res        = {$urandom, $urandom};
            rv.prev_high  = 1'($urandom_range(0, 1));
            rv.mem_act    = 1'b0;
            rv.exp_to     = (lat > TO);
            rv.exp_cycles = rv.exp_to ? TO : lat;
            rv.exp_res    = rv.exp_to ? model_res : rv.res;
            run(rv, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of a run.
        k_w_enable = 1'b0; host_arg = 64'h77; host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", host_busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_res = '0;
        rv = '{64'h42, 3, 64'h1234, 0, 0, 3, 0, 64'h1234};
        run(rv, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
